gate_bias_adder: RTL and testbench
==================================

GATE_BIAS_ADDER -- requirements
Module: gate_bias_adder

Interface
REQ-001 Parameter D_WL, default 24: signed two's-complement lane width.
REQ-002 Parameter UNITS_NUM, default 5: lanes per vector.
REQ-003 Parameter ROWS, default 6: bias rows per sequence; legal range 1..256.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port seq_start, input, 1: one-cycle pulse; restarts the row sequence at row 0.
REQ-007 Port in_valid, input, 1: in_data valid.
REQ-008 Port in_ready, output, 1: block accepts in_data this cycle.
REQ-009 Port in_data, input, UNITS_NUM*D_WL: MAC accumulator vector; lane i = bits [i*D_WL +: D_WL].
REQ-010 Port bias_addr, output, 8: row address to the bias buffer, zero-extended row counter.
REQ-011 Port bias_in, input, UNITS_NUM*D_WL: combinational bias row returned for bias_addr, same lane packing.
REQ-012 Port out_valid, output, 1: out_data valid.
REQ-013 Port out_ready, input, 1: downstream accepts out_data.
REQ-014 Port out_data, output, UNITS_NUM*D_WL: biased, saturated vector.
REQ-015 Port out_last, output, 1: out_data belongs to row ROWS-1.
REQ-016 Port sat_flag, output, 1: sticky; any lane has saturated since reset or seq_start.

Function
REQ-017 Input accept = in_valid & in_ready; output accept = out_valid & out_ready.
REQ-018 in_ready = !out_valid | out_ready, combinationally (single output register, pass-through when drained).
REQ-019 Row counter row_q, range 0..ROWS-1; bias_addr = row_q, driven combinationally from the register.
REQ-020 Per lane, on input accept: sum = sign-extended in_data lane + sign-extended bias_in lane, computed at D_WL+1 bits.
REQ-021 Saturation: sum > 2^(D_WL-1)-1 -> 2^(D_WL-1)-1; sum < -2^(D_WL-1) -> -2^(D_WL-1); otherwise truncate to D_WL bits.
REQ-022 On input accept: out_data <= saturated sums, out_last <= (row_q == ROWS-1), out_valid <= 1; latency exactly 1 cycle.
REQ-023 Output accept without a same-cycle input accept: out_valid <= 0. out_data and out_last hold their values.
REQ-024 While out_valid & !out_ready: out_data, out_last and out_valid hold stable; in_ready = 0.
REQ-025 On input accept: row_q <= (row_q == ROWS-1) ? 0 : row_q + 1; wraps with no gap cycle.
REQ-026 seq_start without input accept: row_q <= 0, sat_flag <= 0.
REQ-027 seq_start with input accept in the same cycle:
  - the accepted vector uses the current row_q;
  - row_q <= 0;
  - sat_flag <= that vector's saturation result only.
REQ-028 sat_flag is set on any input accept in which at least one lane clips; it clears only on rst or seq_start.
REQ-029 An output already held in the register is not affected by seq_start.
REQ-030 Sequence control is row_q alone; no additional FSM states.

Reset
REQ-031 On rst = 1 at a rising edge: row_q = 0, out_valid = 0, out_data = 0, out_last = 0, sat_flag = 0.
REQ-032 rst overrides all simultaneous accepts and seq_start. Data in flight is discarded, not emitted.
REQ-033 During reset: bias_addr = 0 and in_ready = 1, following REQ-018 with out_valid = 0.

Verification
REQ-034 Bench drives bias_in from a 6-row bias buffer model; row 0, lane 0 = 0x004AED.
REQ-035 Basic add: rst, then in_data all lanes 0x000100 with out_ready=1 -> next cycle out_valid=1, lane0=0x004BED, out_last=0, bias_addr=1.
REQ-036 Wrap: 6 back-to-back accepts -> bias_addr sequence 0,1,2,3,4,5,0; out_last=1 only on the 6th output.
REQ-037 Saturation:
  - lane0 in=0x7FFFF0 with bias 0x004AED -> 0x7FFFFF, sat_flag=1;
  - lane in=0x800000 with bias -1 -> 0x800000;
  - sat_flag stays 1 until seq_start.
REQ-038 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_data stable, row_q unchanged; out_ready=1 -> one transfer per cycle resumes, no vector lost or duplicated.
REQ-039 seq_start at row 3 with a concurrent accept -> that vector uses row 3; next bias_addr=0.
REQ-040 Mid-stream rst at row 4 with out_valid=1 -> next cycle out_valid=0, bias_addr=0, sat_flag=0.

Source files
------------

// File: rtl/gate_bias_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gate_bias_adder
//  Purpose  : Adds a per-row bias vector to each incoming MAC accumulator
//             vector, saturating every lane to the signed D_WL-bit range.
//             Bias rows are fetched by row index from an external buffer.
//             The row index advances on every accepted vector and wraps after
//             row ROWS-1. One output register sits between in and out, with
//             pass-through when the register is being drained.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             seq_start         - pulse: restart the row sequence at row 0
//             in_valid/in_ready - input handshake for in_data
//             in_data           - UNITS_NUM lanes of D_WL bits
//             bias_addr         - row address to the bias buffer
//             bias_in           - bias row for bias_addr (combinational)
//             out_valid/out_ready - output handshake for out_data
//             out_data, out_last  - biased vector, last-row marker
//             sat_flag          - sticky: some lane clipped since rst/seq_start
//  Revision : 1.0 - initial release
// ============================================================================
module gate_bias_adder #(
    parameter int D_WL      = 24,
    parameter int UNITS_NUM = 5,
    parameter int ROWS      = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      seq_start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [UNITS_NUM*D_WL-1:0] in_data,
    output logic [7:0]                bias_addr,
    input  logic [UNITS_NUM*D_WL-1:0] bias_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [UNITS_NUM*D_WL-1:0] out_data,
    output logic                      out_last,
    output logic                      sat_flag
);

    localparam int         C_VEC_W    = UNITS_NUM * D_WL;
    localparam logic [7:0] C_LAST_ROW = 8'(ROWS - 1);

    logic [7:0]         row_q,       row_d;
    logic               out_valid_q, out_valid_d;
    logic [C_VEC_W-1:0] out_data_q,  out_data_d;
    logic               out_last_q,  out_last_d;
    logic               sat_q,       sat_d;

    logic               w_in_accept;
    logic               w_out_accept;
    logic               w_any_clip;
    logic               w_last_row;
    logic [C_VEC_W-1:0] w_sat_vec;
    logic [UNITS_NUM-1:0] w_clip;

    // Single output register: it can take a new vector whenever it is empty
    // or is being emptied in this same cycle.
    assign in_ready     = !out_valid_q || out_ready;
    assign w_in_accept  = in_valid && in_ready;
    assign w_out_accept = out_valid_q && out_ready;
    assign w_any_clip   = |w_clip;
    assign w_last_row   = (row_q == C_LAST_ROW);

    generate
        for (genvar g = 0; g < UNITS_NUM; g++) begin : g_lane
            logic [D_WL-1:0] w_a;
            logic [D_WL-1:0] w_b;
            logic [D_WL:0]   w_sum;
            logic            w_ovf;

            assign w_a   = in_data[g*D_WL +: D_WL];
            assign w_b   = bias_in[g*D_WL +: D_WL];
            // One guard bit is enough: the sum of two D_WL-bit values always
            // fits in D_WL+1 bits.
            assign w_sum = {w_a[D_WL-1], w_a} + {w_b[D_WL-1], w_b};
            // Out of range exactly when the guard bit disagrees with the
            // would-be sign bit; the guard bit then gives the clip direction.
            assign w_ovf = w_sum[D_WL] ^ w_sum[D_WL-1];
            assign w_clip[g] = w_ovf;
            assign w_sat_vec[g*D_WL +: D_WL] =
                !w_ovf     ? w_sum[D_WL-1:0] :
                w_sum[D_WL] ? {1'b1, {(D_WL-1){1'b0}}} :
                              {1'b0, {(D_WL-1){1'b1}}};
        end
    endgenerate

    always_comb begin
        row_d       = row_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        sat_d       = sat_q;

        if (w_in_accept) begin
            out_data_d  = w_sat_vec;
            out_last_d  = w_last_row;
            out_valid_d = 1'b1;
            row_d       = w_last_row ? 8'd0 : row_q + 8'd1;
        end else if (w_out_accept) begin
            out_valid_d = 1'b0;
        end

        // A concurrent accept has already used the old row above; seq_start
        // only redirects the next row and restarts the saturation history
        // with this cycle's result.
        if (seq_start) begin
            row_d = 8'd0;
            sat_d = w_in_accept && w_any_clip;
        end else if (w_in_accept && w_any_clip) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q       <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            sat_q       <= sat_d;
        end
    end

    assign bias_addr = row_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign sat_flag  = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_bias_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_gate_bias_adder
//  Purpose  : Self-checking bench for gate_bias_adder. Directed scenarios plus
//             a randomized handshake run scored against a transaction model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gate_bias_adder;

    localparam int D_WL      = 24;
    localparam int UNITS_NUM = 5;
    localparam int ROWS      = 6;
    localparam int VW        = UNITS_NUM * D_WL;

    logic          clk = 1'b0;
    logic          rst;
    logic          seq_start;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_data;
    logic [7:0]    bias_addr;
    logic [VW-1:0] bias_in;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_data;
    logic          out_last;
    logic          sat_flag;

    logic [VW-1:0] bias_mem [ROWS];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gate_bias_adder #(
        .D_WL(D_WL), .UNITS_NUM(UNITS_NUM), .ROWS(ROWS)
    ) dut (
        .clk(clk), .rst(rst), .seq_start(seq_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .bias_addr(bias_addr), .bias_in(bias_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .sat_flag(sat_flag)
    );

    // Bias buffer model: combinational read.
    always_comb begin
        bias_in = '0;
        if (int'(bias_addr) < ROWS) bias_in = bias_mem[int'(bias_addr)];
    end

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        logic [31:0]   r;
        for (int i = 0; i < UNITS_NUM; i++) begin
            r = $urandom();
            v[i*D_WL +: D_WL] = r[D_WL-1:0];
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] fill_vec(input logic [D_WL-1:0] lane);
        logic [VW-1:0] v;
        for (int i = 0; i < UNITS_NUM; i++) v[i*D_WL +: D_WL] = lane;
        return v;
    endfunction

    // Reference: plain integer add, then clamp to the signed D_WL range.
    function automatic logic [VW-1:0] model_vec(input logic [VW-1:0] a,
                                                input logic [VW-1:0] b,
                                                output bit clipped);
        logic [VW-1:0] res;
        longint hi, lo, s;
        logic [D_WL-1:0] la, lb;
        hi = (longint'(1) << (D_WL - 1)) - 1;
        lo = -(longint'(1) << (D_WL - 1));
        clipped = 1'b0;
        for (int i = 0; i < UNITS_NUM; i++) begin
            la = a[i*D_WL +: D_WL];
            lb = b[i*D_WL +: D_WL];
            s  = longint'($signed(la)) + longint'($signed(lb));
            if (s > hi) begin s = hi; clipped = 1'b1; end
            if (s < lo) begin s = lo; clipped = 1'b1; end
            res[i*D_WL +: D_WL] = s[D_WL-1:0];
        end
        return res;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; seq_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; seq_start = 1'b1; in_valid = 1'b1; out_ready = 1'b0; in_data = rand_vec();
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %0b want 0", out_last); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %0b want 0", sat_flag); end
        checks++; if (bias_addr !== 8'd0) begin errors++; $display("FAIL reset_bias_addr: got %0d want 0", bias_addr); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        cyc();
        // Accept attempted while in reset must not be emitted.
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_override: got %0b want 0", out_valid); end
        rst = 1'b0; seq_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_basic_add();
        logic [VW-1:0] exp;
        bit clip;
        apply_reset();
        in_valid = 1'b1; in_data = fill_vec(24'h000100); out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %0b want 1", in_ready); end
        checks++; if (bias_addr !== 8'd0) begin errors++; $display("FAIL basic_addr0: got %0d want 0", bias_addr); end
        exp = model_vec(in_data, bias_mem[0], clip);
        cyc();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %0b want 1", out_valid); end
        checks++; if (out_data[D_WL-1:0] !== 24'h004BED) begin errors++; $display("FAIL basic_lane0: got %h want 004bed", out_data[D_WL-1:0]); end
        checks++; if (out_data !== exp) begin errors++; $display("FAIL basic_vec: got %h want %h", out_data, exp); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL basic_last: got %0b want 0", out_last); end
        checks++; if (bias_addr !== 8'd1) begin errors++; $display("FAIL basic_addr1: got %0d want 1", bias_addr); end
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_wrap();
        logic [VW-1:0] exp;
        bit clip;
        apply_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < ROWS + 1; k++) begin
            in_data = rand_vec();
            #1;
            checks++; if (bias_addr !== 8'(k % ROWS)) begin errors++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", k, bias_addr, k % ROWS); end
            exp = model_vec(in_data, bias_mem[k % ROWS], clip);
            cyc();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid[%0d]: got %0b want 1", k, out_valid); end
            checks++; if (out_data !== exp) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", k, out_data, exp); end
            checks++; if (out_last !== (k == ROWS - 1)) begin errors++; $display("FAIL wrap_last[%0d]: got %0b want %0b", k, out_last, k == ROWS - 1); end
        end
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_saturation();
        logic [VW-1:0] d;
        apply_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        d = '0;
        d[0*D_WL +: D_WL] = 24'h7FFFF0;
        d[1*D_WL +: D_WL] = 24'h800000;
        in_data = d;
        cyc();
        checks++; if (out_data[0*D_WL +: D_WL] !== 24'h7FFFFF) begin errors++; $display("FAIL sat_pos: got %h want 7fffff", out_data[0*D_WL +: D_WL]); end
        checks++; if (out_data[1*D_WL +: D_WL] !== 24'h800000) begin errors++; $display("FAIL sat_neg: got %h want 800000", out_data[1*D_WL +: D_WL]); end
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_set: got %0b want 1", sat_flag); end
        in_data = '0;
        cyc(); cyc();
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %0b want 1", sat_flag); end
        in_valid = 1'b0; seq_start = 1'b1;
        cyc();
        seq_start = 1'b0;
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_clear: got %0b want 0", sat_flag); end
        checks++; if (bias_addr !== 8'd0) begin errors++; $display("FAIL sat_seq_addr: got %0d want 0", bias_addr); end
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] a, b, c, ea, eb, ec;
        bit clip;
        apply_reset();
        a = rand_vec(); b = rand_vec(); c = rand_vec();
        ea = model_vec(a, bias_mem[0], clip);
        eb = model_vec(b, bias_mem[1], clip);
        ec = model_vec(c, bias_mem[2], clip);
        out_ready = 1'b1; in_valid = 1'b1; in_data = a;
        cyc();
        out_ready = 1'b0; in_data = b;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++; if (out_valid !== 1'b1 || out_data !== ea) begin errors++; $display("FAIL bp_hold[%0d]: got v=%0b %h want v=1 %h", k, out_valid, out_data, ea); end
            checks++; if (bias_addr !== 8'd1) begin errors++; $display("FAIL bp_addr[%0d]: got %0d want 1", k, bias_addr); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %0b want 1", in_ready); end
        cyc();
        checks++; if (out_valid !== 1'b1 || out_data !== eb) begin errors++; $display("FAIL bp_b: got v=%0b %h want v=1 %h", out_valid, out_data, eb); end
        in_data = c;
        cyc();
        checks++; if (out_valid !== 1'b1 || out_data !== ec) begin errors++; $display("FAIL bp_c: got v=%0b %h want v=1 %h", out_valid, out_data, ec); end
        in_valid = 1'b0;
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b want 0", out_valid); end
        checks++; if (bias_addr !== 8'd3) begin errors++; $display("FAIL bp_addr_end: got %0d want 3", bias_addr); end
    endtask

    task automatic test_seq_start();
        logic [VW-1:0] d, e;
        bit clip;
        apply_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        d = '0; d[D_WL-1:0] = 24'h7FFFF0;
        in_data = d;
        cyc();
        in_data = '0;
        cyc(); cyc();
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL seq_pre_sat: got %0b want 1", sat_flag); end
        checks++; if (bias_addr !== 8'd3) begin errors++; $display("FAIL seq_pre_addr: got %0d want 3", bias_addr); end
        seq_start = 1'b1;
        cyc();
        seq_start = 1'b0;
        checks++; if (out_data !== bias_mem[3]) begin errors++; $display("FAIL seq_row3: got %h want %h", out_data, bias_mem[3]); end
        checks++; if (bias_addr !== 8'd0) begin errors++; $display("FAIL seq_addr0: got %0d want 0", bias_addr); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL seq_sat_only: got %0b want 0", sat_flag); end
        d = rand_vec();
        in_data = d;
        e = model_vec(d, bias_mem[0], clip);
        cyc();
        checks++; if (out_data !== e) begin errors++; $display("FAIL seq_next_row0: got %h want %h", out_data, e); end
        checks++; if (bias_addr !== 8'd1) begin errors++; $display("FAIL seq_next_addr: got %0d want 1", bias_addr); end
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_mid_reset();
        logic [VW-1:0] d;
        apply_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        d = '0; d[D_WL-1:0] = 24'h7FFFF0;
        in_data = d;
        cyc();
        in_data = '0;
        cyc(); cyc(); cyc();
        checks++; if (bias_addr !== 8'd4 || out_valid !== 1'b1 || sat_flag !== 1'b1) begin errors++; $display("FAIL mrst_pre: got addr=%0d v=%0b s=%0b want addr=4 v=1 s=1", bias_addr, out_valid, sat_flag); end
        rst = 1'b1; in_data = rand_vec();
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %0b want 0", out_valid); end
        checks++; if (bias_addr !== 8'd0) begin errors++; $display("FAIL mrst_addr: got %0d want 0", bias_addr); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL mrst_sat: got %0b want 0", sat_flag); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_discard: got %0b want 0", out_valid); end
    endtask

    task automatic test_random();
        logic [VW-1:0] qd[$];
        bit            ql[$];
        logic [VW-1:0] e, got_e;
        bit   full, msat, clip, exp_rdy, acc, got_l;
        int   row;
        apply_reset();
        full = 1'b0; msat = 1'b0; row = 0;
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom() % 4) != 0;
            out_ready = ($urandom() % 3) != 0;
            seq_start = ($urandom() % 16) == 0;
            in_data   = rand_vec();
            #1;
            exp_rdy = !full || out_ready;
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %0b want %0b", n, in_ready, exp_rdy); end
            checks++; if (bias_addr !== 8'(row)) begin errors++; $display("FAIL rnd_addr[%0d]: got %0d want %0d", n, bias_addr, row); end
            checks++; if (out_valid !== full) begin errors++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", n, out_valid, full); end
            checks++; if (sat_flag !== msat) begin errors++; $display("FAIL rnd_sat[%0d]: got %0b want %0b", n, sat_flag, msat); end
            if (full && out_ready && qd.size() > 0) begin
                got_e = qd.pop_front();
                got_l = ql.pop_front();
                checks++; if (out_data !== got_e || out_last !== got_l) begin errors++; $display("FAIL rnd_data[%0d]: got %h l=%0b want %h l=%0b", n, out_data, out_last, got_e, got_l); end
                full = 1'b0;
            end
            acc  = in_valid && exp_rdy;
            clip = 1'b0;
            if (acc) begin
                e = model_vec(in_data, bias_mem[row], clip);
                qd.push_back(e);
                ql.push_back(row == ROWS - 1);
                full = 1'b1;
                row  = (row + 1) % ROWS;
                msat = msat || clip;
            end
            if (seq_start) begin
                row  = 0;
                msat = acc && clip;
            end
            cyc();
        end
        in_valid = 1'b0; seq_start = 1'b0; out_ready = 1'b1;
        cyc();
    endtask

    initial begin
        rst = 1'b1; seq_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        for (int r = 0; r < ROWS; r++) bias_mem[r] = rand_vec();
        bias_mem[0][0*D_WL +: D_WL] = 24'h004AED;
        bias_mem[0][1*D_WL +: D_WL] = 24'hFFFFFF;
        cyc();
        test_reset();
        test_basic_add();
        test_wrap();
        test_saturation();
        test_backpressure();
        test_seq_start();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
